// File: rtl/gray_step_monitor.sv
// gray_step_monitor: synchronises an asynchronous Gray bus, decodes it to
// binary and classifies each sample-to-sample move as hold, +1, -1 or illegal.
// Optional feature macro: GRAY_MON_DIR_EN (defined = -1 steps are legal and
// drive step_down; undefined = step_down tied low and -1 counts as an error).
module gray_step_monitor #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             step_err,
  output logic             sticky_err,
  output logic [7:0]       err_cnt,
  output logic             locked
);

  localparam int FW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_ERROR} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [FW-1:0]    fill_q, fill_d;
  logic [3:0]       good_q, good_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             valid_q, valid_d;
  logic             up_q, up_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_new, delta;
  logic             is_hold, is_up, is_dn;
`ifdef GRAY_MON_DIR_EN
  logic             dn_q, dn_d;
`endif

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int unsigned i = 2; i <= WIDTH; i++) begin
      b[WIDTH-i] = b[WIDTH-i+1] ^ g[WIDTH-i];
    end
    return b;
  endfunction

  // Synchroniser chain for the asynchronous Gray input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Decode and step classification against the previously registered sample.
  always_comb begin
    bin_new = gray2bin(sync_q[SYNC_STAGES-1]);
    delta   = bin_new - bin_q;
    is_hold = (delta == '0);
    is_up   = (delta == WIDTH'(1));
`ifdef GRAY_MON_DIR_EN
    is_dn   = (delta == '1);
`else
    is_dn   = 1'b0;
`endif
  end

  // Next-state logic: fill / track / error FSM plus error bookkeeping.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    good_d   = good_q;
    bin_d    = bin_q;
    valid_d  = valid_q;
    up_d     = 1'b0;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
`ifdef GRAY_MON_DIR_EN
    dn_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Wait for the chain to flush post-reset, then take the first sample
        // as the reference without classifying it.
        if (fill_q == FW'(SYNC_STAGES)) begin
          bin_d   = bin_new;
          valid_d = 1'b1;
          state_d = S_TRACK;
        end else begin
          fill_d = fill_q + FW'(1);
        end
      end
      S_TRACK, S_ERROR: begin
        bin_d = bin_new;
        up_d  = is_up;
`ifdef GRAY_MON_DIR_EN
        dn_d  = is_dn;
`endif
        err_d = !(is_hold || is_up || is_dn);
        if (err_d) begin
          state_d = S_ERROR;
          good_d  = '0;
        end else if (state_q == S_ERROR) begin
          if (good_q == 4'(LOCK_LEN - 1)) begin
            state_d = S_TRACK;
            good_d  = '0;
          end else begin
            good_d = good_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clr_err) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (err_d) begin
      sticky_d = 1'b1;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      fill_q   <= '0;
      good_q   <= '0;
      bin_q    <= '0;
      valid_q  <= 1'b0;
      up_q     <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
`ifdef GRAY_MON_DIR_EN
      dn_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      good_q   <= good_d;
      bin_q    <= bin_d;
      valid_q  <= valid_d;
      up_q     <= up_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
`ifdef GRAY_MON_DIR_EN
      dn_q     <= dn_d;
`endif
    end
  end

  assign bin_out    = bin_q;
  assign bin_valid  = valid_q;
  assign step_up    = up_q;
  assign step_err   = err_q;
  assign sticky_err = sticky_q;
  assign err_cnt    = cnt_q;
  assign locked     = (state_q == S_TRACK);
`ifdef GRAY_MON_DIR_EN
  assign step_down  = dn_q;
`else
  assign step_down  = 1'b0;
`endif

endmodule
